fft_frame_buffer: RTL and testbench

- Parametrised ping-pong frame buffer that replaces single-shot parallel sample registers in front of the FFT core.
- Accepts complex samples serially with a valid/ready handshake and assembles them into an N-point frame, optionally in bit-reversed order.
- Presents the completed frame to the FFT core as flattened parallel buses with a valid/ack handshake.
- Two banks allow frame k+1 to fill while frame k is being consumed.

---
 rtl/fft_pkg.sv | 26 ++
 rtl/fft_bank.sv | 40 ++++
 rtl/fft_frame_buffer.sv | 160 ++++++++++++++++
 tb/tb_fft_frame_buffer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT input frame buffer: default sizes, the
// fill/full state encoding and the bit-reversal helper used for write addressing.
package fft_pkg;

    localparam int WORD_SIZE_DEF = 16;
    localparam int N_POINTS_DEF  = 16;
    localparam int ADDR_W_DEF    = $clog2(N_POINTS_DEF);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } fill_state_t;

    // Reverses the low 'width' bits of v; bits above 'width' come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int width);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                r[i] = v[width-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bank.sv
// One frame bank: N_POINTS complex registers with a single write port and
// every position presented in parallel on flattened buses.
module fft_bank
    import fft_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int N_POINTS  = N_POINTS_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_wrEn,
    input  logic [ADDR_W-1:0]             i_wrAddr,
    input  logic [WORD_SIZE-1:0]          i_wrRe,
    input  logic [WORD_SIZE-1:0]          i_wrIm,
    output logic [N_POINTS*WORD_SIZE-1:0] o_rdRe,
    output logic [N_POINTS*WORD_SIZE-1:0] o_rdIm
);

    logic [WORD_SIZE-1:0] r_re [N_POINTS];
    logic [WORD_SIZE-1:0] r_im [N_POINTS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < N_POINTS; p++) begin
                r_re[p] <= '0;
                r_im[p] <= '0;
            end
        end else if (i_wrEn) begin
            r_re[i_wrAddr] <= i_wrRe;
            r_im[i_wrAddr] <= i_wrIm;
        end
    end

    for (genvar p = 0; p < N_POINTS; p++) begin : g_flatten
        assign o_rdRe[p*WORD_SIZE +: WORD_SIZE] = r_re[p];
        assign o_rdIm[p*WORD_SIZE +: WORD_SIZE] = r_im[p];
    end

endmodule

// File: rtl/fft_frame_buffer.sv
// Ping-pong frame buffer in front of the FFT core: serial samples fill one bank
// while the other bank is presented to the core as a complete parallel frame.
module fft_frame_buffer
    import fft_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int N_POINTS  = N_POINTS_DEF,
    parameter int ADDR_W    = $clog2(N_POINTS),
    parameter int BITREV    = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WORD_SIZE-1:0]          in_re,
    input  logic [WORD_SIZE-1:0]          in_im,
    input  logic                          flush,
    output logic                          out_valid,
    input  logic                          out_ack,
    output logic [N_POINTS*WORD_SIZE-1:0] out_re,
    output logic [N_POINTS*WORD_SIZE-1:0] out_im,
    output logic [ADDR_W:0]               wr_count,
    output logic [7:0]                    frames_done
);

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(N_POINTS - 1);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(N_POINTS);

    fill_state_t     r_state;
    fill_state_t     w_stateNext;
    logic            r_wrBank;
    logic            w_wrBankNext;
    logic [ADDR_W:0] r_wrCount;
    logic [ADDR_W:0] w_wrCountNext;
    logic            r_outValid;
    logic            w_outValidNext;
    logic [7:0]      r_frames;
    logic [7:0]      w_framesNext;

    logic              w_wrEn;
    logic              w_lastWrite;
    logic [ADDR_W-1:0] w_wrAddr;

    logic [N_POINTS*WORD_SIZE-1:0] w_bank0Re;
    logic [N_POINTS*WORD_SIZE-1:0] w_bank0Im;
    logic [N_POINTS*WORD_SIZE-1:0] w_bank1Re;
    logic [N_POINTS*WORD_SIZE-1:0] w_bank1Im;

    // A flush wins over any sample offered in the same cycle.
    assign in_ready    = (r_state == ST_FILL);
    assign w_wrEn      = in_valid && in_ready && !flush;
    assign w_lastWrite = w_wrEn && (r_wrCount == LAST_IDX);

    assign w_wrAddr = (BITREV != 0)
                    ? ADDR_W'(bitrev(32'(r_wrCount[ADDR_W-1:0]), ADDR_W))
                    : r_wrCount[ADDR_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_FILL;
            r_wrBank   <= 1'b0;
            r_wrCount  <= '0;
            r_outValid <= 1'b0;
            r_frames   <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_wrBank   <= w_wrBankNext;
            r_wrCount  <= w_wrCountNext;
            r_outValid <= w_outValidNext;
            r_frames   <= w_framesNext;
        end
    end

    // A swap hands the filled bank to the reader and starts a fresh fill;
    // it always leaves out_valid high, so a simultaneous ack never drops it.
    always_comb begin
        w_stateNext    = r_state;
        w_wrBankNext   = r_wrBank;
        w_wrCountNext  = r_wrCount;
        w_outValidNext = r_outValid;
        w_framesNext   = r_frames;

        if (r_outValid && out_ack) begin
            w_outValidNext = 1'b0;
        end

        case (r_state)
            ST_FILL: begin
                if (flush) begin
                    w_wrCountNext = '0;
                end else if (w_lastWrite) begin
                    if (!r_outValid || out_ack) begin
                        w_wrBankNext   = ~r_wrBank;
                        w_wrCountNext  = '0;
                        w_outValidNext = 1'b1;
                        w_framesNext   = r_frames + 8'd1;
                    end else begin
                        w_stateNext   = ST_FULL;
                        w_wrCountNext = FULL_CNT;
                    end
                end else if (w_wrEn) begin
                    w_wrCountNext = r_wrCount + 1'b1;
                end
            end
            ST_FULL: begin
                if (flush) begin
                    w_stateNext   = ST_FILL;
                    w_wrCountNext = '0;
                end else if (out_ack) begin
                    w_stateNext    = ST_FILL;
                    w_wrBankNext   = ~r_wrBank;
                    w_wrCountNext  = '0;
                    w_outValidNext = 1'b1;
                    w_framesNext   = r_frames + 8'd1;
                end
            end
            default: begin
                w_stateNext = ST_FILL;
            end
        endcase
    end

    fft_bank #(
        .WORD_SIZE(WORD_SIZE),
        .N_POINTS (N_POINTS),
        .ADDR_W   (ADDR_W)
    ) u_bank0 (
        .clk     (clk),
        .rst     (rst),
        .i_wrEn  (w_wrEn && !r_wrBank),
        .i_wrAddr(w_wrAddr),
        .i_wrRe  (in_re),
        .i_wrIm  (in_im),
        .o_rdRe  (w_bank0Re),
        .o_rdIm  (w_bank0Im)
    );

    fft_bank #(
        .WORD_SIZE(WORD_SIZE),
        .N_POINTS (N_POINTS),
        .ADDR_W   (ADDR_W)
    ) u_bank1 (
        .clk     (clk),
        .rst     (rst),
        .i_wrEn  (w_wrEn && r_wrBank),
        .i_wrAddr(w_wrAddr),
        .i_wrRe  (in_re),
        .i_wrIm  (in_im),
        .o_rdRe  (w_bank1Re),
        .o_rdIm  (w_bank1Im)
    );

    // The read bank is whichever bank is not being filled.
    assign out_re      = r_wrBank ? w_bank0Re : w_bank1Re;
    assign out_im      = r_wrBank ? w_bank0Im : w_bank1Im;
    assign out_valid   = r_outValid;
    assign wr_count    = r_wrCount;
    assign frames_done = r_frames;

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Directed bench for fft_frame_buffer: a linear-order and a bit-reversed
// instance receive the same sample stream and are checked against hand values.
module tb_fft_frame_buffer;

    localparam int W  = 16;
    localparam int NP = 16;
    localparam int AW = 4;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  in_re;
    logic [W-1:0]  in_im;
    logic          flush;
    logic          out_ack;

    logic          in_ready;
    logic          out_valid;
    logic [NP*W-1:0] out_re;
    logic [NP*W-1:0] out_im;
    logic [AW:0]   wr_count;
    logic [7:0]    frames_done;

    logic          revInReady;
    logic          revOutValid;
    logic [NP*W-1:0] revOutRe;
    logic [NP*W-1:0] revOutIm;
    logic [AW:0]   revWrCount;
    logic [7:0]    revFramesDone;

    int errors = 0;
    int checks = 0;

    fft_frame_buffer #(.WORD_SIZE(W), .N_POINTS(NP), .ADDR_W(AW), .BITREV(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_re      (in_re),
        .in_im      (in_im),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ack    (out_ack),
        .out_re     (out_re),
        .out_im     (out_im),
        .wr_count   (wr_count),
        .frames_done(frames_done)
    );

    fft_frame_buffer #(.WORD_SIZE(W), .N_POINTS(NP), .ADDR_W(AW), .BITREV(1)) dutRev (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (revInReady),
        .in_re      (in_re),
        .in_im      (in_im),
        .flush      (flush),
        .out_valid  (revOutValid),
        .out_ack    (out_ack),
        .out_re     (revOutRe),
        .out_im     (revOutIm),
        .wr_count   (revWrCount),
        .frames_done(revFramesDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int re, input int im);
        in_valid = 1'b1;
        in_re    = W'(re);
        in_im    = W'(im);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic sendSamples(input int base, input int count);
        for (int k = 0; k < count; k++) begin
            applyStimulus(base + k, -(base + k));
        end
    endtask

    function automatic logic [NP*W-1:0] frameRe(input int base);
        logic [NP*W-1:0] bus;
        for (int p = 0; p < NP; p++) bus[p*W +: W] = W'(base + p);
        return bus;
    endfunction

    function automatic logic [NP*W-1:0] frameIm(input int base);
        logic [NP*W-1:0] bus;
        for (int p = 0; p < NP; p++) bus[p*W +: W] = W'(-(base + p));
        return bus;
    endfunction

    initial begin
        int revTable [NP] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
        logic [NP*W-1:0] revExp;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_re    = '0;
        in_im    = '0;
        flush    = 1'b0;
        out_ack  = 1'b0;

        #2;
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset wr_count", wr_count, 0);
        checkOutput("reset frames_done", frames_done, 0);
        checkOutput("reset out_re", out_re, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("in_ready after reset", in_ready, 1);

        // Frame 0: re=k, im=-k, no ack
        sendSamples(0, 15);
        checkOutput("out_valid before last sample", out_valid, 0);
        checkOutput("wr_count after 15", wr_count, 15);
        sendSamples(15, 1);
        checkOutput("frame0 out_valid", out_valid, 1);
        checkOutput("frame0 out_re", out_re, frameRe(0));
        checkOutput("frame0 out_im", out_im, frameIm(0));
        checkOutput("frame0 frames_done", frames_done, 1);
        checkOutput("frame0 wr_count", wr_count, 0);
        checkOutput("frame0 in_ready", in_ready, 1);

        for (int p = 0; p < NP; p++) revExp[p*W +: W] = W'(revTable[p]);
        checkOutput("bitrev out_re", revOutRe, revExp);
        checkOutput("bitrev pos1", revOutRe[1*W +: W], 8);
        checkOutput("bitrev pos3", revOutRe[3*W +: W], 12);
        checkOutput("bitrev pos15", revOutRe[15*W +: W], 15);

        // Frame 1 fills while frame 0 is unacknowledged
        sendSamples(100, 16);
        checkOutput("full in_ready", in_ready, 0);
        checkOutput("full wr_count", wr_count, 16);
        checkOutput("full out_re still frame0", out_re, frameRe(0));
        checkOutput("full frames_done", frames_done, 1);
        checkOutput("full out_valid", out_valid, 1);
        applyStimulus(999, 999);
        checkOutput("full ignores sample", wr_count, 16);
        checkOutput("full holds frame0", out_re, frameRe(0));

        out_ack = 1'b1;
        @(posedge clk);
        #1;
        out_ack = 1'b0;
        checkOutput("ack swap out_re", out_re, frameRe(100));
        checkOutput("ack swap out_im", out_im, frameIm(100));
        checkOutput("ack swap in_ready", in_ready, 1);
        checkOutput("ack swap frames_done", frames_done, 2);
        checkOutput("ack swap out_valid", out_valid, 1);
        checkOutput("ack swap wr_count", wr_count, 0);

        // Frame 2: ack coincides with the last accepted sample
        sendSamples(200, 15);
        checkOutput("pre-coincident out_valid", out_valid, 1);
        out_ack = 1'b1;
        sendSamples(215, 1);
        out_ack = 1'b0;
        checkOutput("coincident out_valid", out_valid, 1);
        checkOutput("coincident frames_done", frames_done, 3);
        checkOutput("coincident out_re", out_re, frameRe(200));
        checkOutput("coincident in_ready", in_ready, 1);

        // Plain ack releases the frame; ack with nothing presented is ignored
        out_ack = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("ack clears out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        out_ack = 1'b0;
        checkOutput("idle ack out_valid", out_valid, 0);
        checkOutput("idle ack frames_done", frames_done, 3);

        // Flush after 5 samples, with a sample offered in the same cycle
        sendSamples(85, 5);
        checkOutput("pre-flush wr_count", wr_count, 5);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_re    = 16'h00AA;
        in_im    = 16'h00AA;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("flush wr_count", wr_count, 0);
        checkOutput("flush out_valid", out_valid, 0);
        sendSamples(300, 16);
        checkOutput("post-flush out_valid", out_valid, 1);
        checkOutput("post-flush out_re", out_re, frameRe(300));
        checkOutput("post-flush out_im", out_im, frameIm(300));
        checkOutput("post-flush frames_done", frames_done, 4);

        // Asynchronous reset mid-frame, checked before the next clock edge
        sendSamples(400, 9);
        checkOutput("pre-reset wr_count", wr_count, 9);
        checkOutput("pre-reset out_valid", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async reset wr_count", wr_count, 0);
        checkOutput("async reset out_valid", out_valid, 0);
        checkOutput("async reset out_re", out_re, 0);
        checkOutput("async reset frames_done", frames_done, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
